// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and helpers for the register file / scoreboard slice.
package regfile_scoreboard_pkg;

  // Default geometry of the architectural register file.
  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_NREG  = 32;
  localparam int unsigned DEF_TAG_W = 4;
  localparam int unsigned DEF_NRD   = 2;

  // Hard-wired zero register index and the all-zero data word.
  localparam int unsigned             ZERO_REG  = 0;
  localparam logic [DEF_XLEN-1:0]     ZERO_WORD = {DEF_XLEN{1'b0}};

  // Address width for a register file of n entries.
  function automatic int unsigned addr_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// Single read port: register lookup with same-cycle commit bypass.
module regfile_read_port
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned NREG  = DEF_NREG,
  parameter int unsigned TAG_W = DEF_TAG_W,
  parameter int unsigned AW    = addr_width(NREG)
) (
  input  logic                            rst,
  input  logic                            rd_en,
  input  logic [AW-1:0]                   rd_addr,
  input  logic                            cm_en,
  input  logic [AW-1:0]                   cm_addr,
  input  logic [TAG_W-1:0]                cm_tag,
  input  logic [XLEN-1:0]                 cm_data,
  input  logic [NREG-1:0][XLEN-1:0]       reg_data,
  input  logic [NREG-1:0]                 reg_busy,
  input  logic [NREG-1:0][TAG_W-1:0]      reg_tag,
  output logic [XLEN-1:0]                 rd_data,
  output logic                            rd_busy,
  output logic [TAG_W-1:0]                rd_tag
);

  logic [XLEN-1:0]  data_s;
  logic             busy_s;
  logic [TAG_W-1:0] tag_s;

  // Select stored state or the in-flight commit; a commit only frees the
  // register when its tag matches the latest rename.
  always_comb begin
    data_s = XLEN'(ZERO_WORD);
    busy_s = 1'b0;
    tag_s  = {TAG_W{1'b0}};
    if (rst || !rd_en) begin
      data_s = XLEN'(ZERO_WORD);
    end else if (rd_addr == AW'(ZERO_REG)) begin
      data_s = XLEN'(ZERO_WORD);
    end else if (cm_en && (cm_addr == rd_addr)) begin
      data_s = cm_data;
      busy_s = reg_busy[rd_addr] && (reg_tag[rd_addr] != cm_tag);
      tag_s  = busy_s ? reg_tag[rd_addr] : {TAG_W{1'b0}};
    end else begin
      data_s = reg_data[rd_addr];
      busy_s = reg_busy[rd_addr];
      tag_s  = reg_busy[rd_addr] ? reg_tag[rd_addr] : {TAG_W{1'b0}};
    end
  end

  assign rd_data = data_s;
  assign rd_busy = busy_s;
  assign rd_tag  = tag_s;

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with per-register busy/tag scoreboard.
// Issue renames a destination to a ROB tag; commit writes data and frees
// the register only if no younger rename has replaced the tag.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned NREG  = DEF_NREG,
  parameter int unsigned TAG_W = DEF_TAG_W,
  parameter int unsigned NRD   = DEF_NRD,
  localparam int unsigned AW   = addr_width(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   cm_en,
  input  logic [AW-1:0]          cm_addr,
  input  logic [TAG_W-1:0]       cm_tag,
  input  logic [XLEN-1:0]        cm_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  input  logic [TAG_W-1:0]       iss_tag,
  input  logic [NRD-1:0]         rd_en,
  input  logic [NRD*AW-1:0]      rd_addr,
  output logic [NRD*XLEN-1:0]    rd_data,
  output logic [NRD-1:0]         rd_busy,
  output logic [NRD*TAG_W-1:0]   rd_tag
);

  logic [NREG-1:0][XLEN-1:0]  data_r;
  logic [NREG-1:0]            busy_r;
  logic [NREG-1:0][TAG_W-1:0] tag_r;

  logic cm_wr_s;
  logic iss_wr_s;

  assign cm_wr_s  = cm_en  && (cm_addr  != AW'(ZERO_REG));
  assign iss_wr_s = iss_en && (iss_addr != AW'(ZERO_REG)) && !flush;

  // State update; later assignments win, so flush beats commit-clear and
  // issue beats commit-clear on the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= '0;
      busy_r <= '0;
      tag_r  <= '0;
    end else begin
      if (cm_wr_s) begin
        data_r[cm_addr] <= cm_data;
        if (busy_r[cm_addr] && (tag_r[cm_addr] == cm_tag)) begin
          busy_r[cm_addr] <= 1'b0;
        end
      end
      if (flush) begin
        busy_r <= '0;
      end else if (iss_wr_s) begin
        busy_r[iss_addr] <= 1'b1;
        tag_r[iss_addr]  <= iss_tag;
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_read_port #(
      .XLEN  (XLEN),
      .NREG  (NREG),
      .TAG_W (TAG_W),
      .AW    (AW)
    ) u_port (
      .rst      (rst),
      .rd_en    (rd_en[i]),
      .rd_addr  (rd_addr[i*AW +: AW]),
      .cm_en    (cm_en),
      .cm_addr  (cm_addr),
      .cm_tag   (cm_tag),
      .cm_data  (cm_data),
      .reg_data (data_r),
      .reg_busy (busy_r),
      .reg_tag  (tag_r),
      .rd_data  (rd_data[i*XLEN +: XLEN]),
      .rd_busy  (rd_busy[i]),
      .rd_tag   (rd_tag[i*TAG_W +: TAG_W])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard: directed scenarios plus random traffic
// checked against a behavioural register/scoreboard model.
module tb_regfile_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int TAG_W = 4;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                 clk = 1'b0;
  logic                 rst, flush, cm_en, iss_en;
  logic [AW-1:0]        cm_addr, iss_addr;
  logic [TAG_W-1:0]     cm_tag, iss_tag;
  logic [XLEN-1:0]      cm_data;
  logic [NRD-1:0]       rd_en;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NRD*TAG_W-1:0] rd_tag;

  int vectors = 0;
  int miscompares = 0;

  logic [XLEN-1:0]  m_data [NREG];
  logic             m_busy [NREG];
  logic [TAG_W-1:0] m_tag  [NREG];

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cm_en(cm_en), .cm_addr(cm_addr), .cm_tag(cm_tag), .cm_data(cm_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_tag(iss_tag),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Compare every port against the model in the current cycle.
  task automatic check_model();
    for (int p = 0; p < NRD; p++) begin
      int a;
      logic [XLEN-1:0]  ed;
      logic             eb;
      logic [TAG_W-1:0] et;
      a  = int'(rd_addr[p*AW +: AW]);
      ed = '0; eb = 1'b0; et = '0;
      if (rst || !rd_en[p] || a == 0) begin
        ed = '0;
      end else if (cm_en && int'(cm_addr) == a) begin
        ed = cm_data;
        eb = m_busy[a] && (m_tag[a] != cm_tag);
        et = eb ? m_tag[a] : '0;
      end else begin
        ed = m_data[a];
        eb = m_busy[a];
        et = eb ? m_tag[a] : '0;
      end
      chk($sformatf("model_data_p%0d", p), 64'(rd_data[p*XLEN +: XLEN]), 64'(ed));
      chk($sformatf("model_busy_p%0d", p), 64'(rd_busy[p]), 64'(eb));
      chk($sformatf("model_tag_p%0d", p), 64'(rd_tag[p*TAG_W +: TAG_W]), 64'(et));
    end
  endtask

  // Apply the clock edge's effect to the model.
  task automatic update_model();
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
      end
    end else begin
      if (cm_en && cm_addr != 0) begin
        m_data[cm_addr] = cm_data;
        if (m_busy[cm_addr] && m_tag[cm_addr] == cm_tag) m_busy[cm_addr] = 1'b0;
      end
      if (flush) begin
        for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
      end else if (iss_en && iss_addr != 0) begin
        m_busy[iss_addr] = 1'b1;
        m_tag[iss_addr]  = iss_tag;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; cm_en = 1'b0; iss_en = 1'b0;
    cm_addr = '0; cm_tag = '0; cm_data = '0;
    iss_addr = '0; iss_tag = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  task automatic rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic commit(input int a, input int t, input logic [XLEN-1:0] d);
    cm_en = 1'b1; cm_addr = AW'(a); cm_tag = TAG_W'(t); cm_data = d;
  endtask

  task automatic issue(input int a, input int t);
    iss_en = 1'b1; iss_addr = AW'(a); iss_tag = TAG_W'(t);
  endtask

  // Directed check against hand-derived constants.
  task automatic probe(input int p, input logic [XLEN-1:0] d, input logic b,
                       input logic [TAG_W-1:0] t, input string name);
    #1;
    chk({name, "_data"}, 64'(rd_data[p*XLEN +: XLEN]), 64'(d));
    chk({name, "_busy"}, 64'(rd_busy[p]), 64'(b));
    chk({name, "_tag"}, 64'(rd_tag[p*TAG_W +: TAG_W]), 64'(t));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    rd(0, 5); rd(1, 5);
    commit(5, 3, 32'hCAFE_F00D);
    probe(0, 32'h0, 1'b0, 4'h0, "in_reset");
    tick(); tick();
    rst = 1'b0;
    idle();

    // Reset state and commit with same-cycle bypass.
    rd(0, 5); rd(1, 5);
    probe(0, 32'h0, 1'b0, 4'h0, "post_rst_p0");
    probe(1, 32'h0, 1'b0, 4'h0, "post_rst_p1");
    tick();
    commit(5, 3, 32'hDEAD_BEEF);
    probe(0, 32'hDEAD_BEEF, 1'b0, 4'h0, "cm_bypass");
    tick(); idle(); rd(1, 5);
    probe(1, 32'hDEAD_BEEF, 1'b0, 4'h0, "cm_stored");
    tick();

    // Rename then matching commit.
    idle(); issue(7, 2); rd(0, 7);
    probe(0, 32'h0, 1'b0, 4'h0, "iss_not_yet_visible");
    tick(); idle(); rd(0, 7);
    probe(0, 32'h0, 1'b1, 4'h2, "iss_visible");
    tick(); commit(7, 2, 32'h11);
    probe(0, 32'h11, 1'b0, 4'h0, "cm_match_bypass");
    tick();

    // Younger rename survives an older commit.
    idle(); issue(7, 2); tick();
    idle(); issue(7, 5); tick();
    idle(); commit(7, 2, 32'h22); rd(0, 7);
    probe(0, 32'h22, 1'b1, 4'h5, "cm_stale_bypass");
    tick(); idle(); rd(1, 7);
    probe(1, 32'h22, 1'b1, 4'h5, "cm_stale_stored");
    tick();

    // Same-cycle issue and commit to one register: issue wins.
    idle(); issue(9, 6); commit(9, 1, 32'h33); tick();
    idle(); rd(0, 9);
    probe(0, 32'h33, 1'b1, 4'h6, "iss_cm_same");
    tick();

    // Flush clears everything and drops the concurrent issue.
    for (int r = 1; r <= 4; r++) begin
      idle(); issue(r, r); tick();
    end
    idle(); flush = 1'b1; issue(8, 7); rd(0, 1); rd(1, 4);
    probe(0, 32'h0, 1'b1, 4'h1, "flush_cycle_p0");
    probe(1, 32'h0, 1'b1, 4'h4, "flush_cycle_p1");
    tick();
    idle(); rd(0, 8); rd(1, 2);
    probe(0, 32'h0, 1'b0, 4'h0, "flush_iss_dropped");
    probe(1, 32'h0, 1'b0, 4'h0, "flush_cleared");
    tick();
    idle(); rd(0, 7); rd(1, 9);
    probe(0, 32'h22, 1'b0, 4'h0, "flush_x7");
    probe(1, 32'h33, 1'b0, 4'h0, "flush_x9");
    tick();

    // Register zero and disabled ports.
    idle(); issue(0, 3); commit(0, 3, 32'hFFFF_FFFF); rd(0, 0);
    probe(0, 32'h0, 1'b0, 4'h0, "x0_same");
    tick(); idle(); rd(0, 0);
    probe(0, 32'h0, 1'b0, 4'h0, "x0_after");
    tick();
    idle(); rd_addr = {AW'(5), AW'(9)};
    probe(0, 32'h0, 1'b0, 4'h0, "rd_en_low_p0");
    probe(1, 32'h0, 1'b0, 4'h0, "rd_en_low_p1");
    tick();

    // Random traffic over a narrow address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(63) == 0);
      flush    = ($urandom_range(15) == 0);
      cm_en    = $urandom_range(1);
      cm_addr  = AW'($urandom_range(7));
      cm_tag   = TAG_W'($urandom_range(3));
      cm_data  = $urandom;
      iss_en   = $urandom_range(1);
      iss_addr = AW'($urandom_range(7));
      iss_tag  = TAG_W'($urandom_range(3));
      rd_en    = NRD'($urandom_range(3));
      rd_addr  = {AW'($urandom_range(7)), AW'($urandom_range(7))};
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
